// File: rtl/ats_pkg.sv
// Shared helpers for the ATS ingress path: footer sizing, keep popcount and
// saturating arithmetic used by the frame-length counters.
package ats_pkg;

  localparam int KEEP_MAX = 128;

  function automatic int unsigned ts_bytes(input bit enable, input int unsigned width);
    return enable ? width / 8 : 0;
  endfunction

  function automatic logic [31:0] popcount(input logic [KEEP_MAX-1:0] keep);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < KEEP_MAX; i++) n += {31'd0, keep[i]};
    return n;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] cap);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, cap}) ? cap : s[31:0];
  endfunction

endpackage

// File: rtl/axis_register_slice.sv
// One-stage AXI4-Stream output register; contents clear once consumed with
// nothing new behind them.
module axis_register_slice #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [KEEP_WIDTH-1:0] s_tkeep,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [KEEP_WIDTH-1:0] m_tkeep,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast
);

  assign s_tready = !m_tvalid || m_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
      m_tvalid <= 1'b0;
    end else if (s_tvalid && s_tready) begin
      m_tdata  <= s_tdata;
      m_tkeep  <= s_tkeep;
      m_tlast  <= s_tlast;
      m_tvalid <= 1'b1;
    end else if (m_tready) begin
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_frame_length_tap.sv
// Cut-through frame tap: forwards the stream through a register slice and
// reports each frame's payload byte count (footer excluded) on a side channel.
module axis_frame_length_tap
  import ats_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH      = 8,
  parameter int C_AXIS_TKEEP_WIDTH      = C_AXIS_TDATA_WIDTH / 8,
  parameter int FRAME_LENGTH_WIDTH      = 16,
  parameter int ETHERNET_FRAME_WIDTH    = 1600 * C_AXIS_TDATA_WIDTH,
  parameter int ENABLE_TIMESTAMP_FOOTER = 1,
  parameter int TIMESTAMP_WIDTH         = 72
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [FRAME_LENGTH_WIDTH-1:0] m_axis_frame_length_tdata,
  output logic                          m_axis_frame_length_tvalid,
  input  logic                          m_axis_frame_length_tready
);

  localparam logic [31:0] TS_B      = 32'(ts_bytes(ENABLE_TIMESTAMP_FOOTER != 0, TIMESTAMP_WIDTH));
  localparam logic [31:0] LEN_MAX   = 32'((64'(1) << FRAME_LENGTH_WIDTH) - 64'(1));
  localparam logic [31:0] FRAME_MAX = 32'(ETHERNET_FRAME_WIDTH / 8);
  // Counter ceiling sits above both the largest legal frame and the length
  // saturation point, so oversize frames still saturate the reported length.
  localparam logic [31:0] CNT_CAP   = ((FRAME_MAX > LEN_MAX) ? FRAME_MAX : LEN_MAX) + TS_B;

  logic        slice_ready, accept, stall, len_full;
  logic [31:0] cnt, beat_bytes, total, payload, len_calc;

  assign len_full      = m_axis_frame_length_tvalid;
  // A tlast may only enter when the length slot is free or being drained now.
  assign stall         = s_axis_tlast && len_full && !m_axis_frame_length_tready;
  assign s_axis_tready = !rst && slice_ready && !stall;
  assign accept        = s_axis_tvalid && s_axis_tready;

  assign beat_bytes = popcount(KEEP_MAX'(s_axis_tkeep));
  assign total      = sat_add(cnt, beat_bytes, CNT_CAP);

  always_comb begin
    payload  = (total > TS_B) ? total - TS_B : 32'd0;
    len_calc = (payload > LEN_MAX) ? LEN_MAX : payload;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt                        <= '0;
      m_axis_frame_length_tvalid <= 1'b0;
      m_axis_frame_length_tdata  <= '0;
    end else if (accept && s_axis_tlast) begin
      cnt                        <= '0;
      m_axis_frame_length_tvalid <= 1'b1;
      m_axis_frame_length_tdata  <= len_calc[FRAME_LENGTH_WIDTH-1:0];
    end else begin
      if (accept) cnt <= total;
      if (m_axis_frame_length_tready) m_axis_frame_length_tvalid <= 1'b0;
    end
  end

  axis_register_slice #(
    .DATA_WIDTH(C_AXIS_TDATA_WIDTH),
    .KEEP_WIDTH(C_AXIS_TKEEP_WIDTH)
  ) u_out (
    .clk     (clk),
    .rst     (rst),
    .s_tdata (s_axis_tdata),
    .s_tkeep (s_axis_tkeep),
    .s_tvalid(accept),
    .s_tready(slice_ready),
    .s_tlast (s_axis_tlast),
    .m_tdata (m_axis_tdata),
    .m_tkeep (m_axis_tkeep),
    .m_tvalid(m_axis_tvalid),
    .m_tready(m_axis_tready),
    .m_tlast (m_axis_tlast)
  );

endmodule

// File: tb/tb_axis_frame_length_tap.sv
// Scoreboard bench for axis_frame_length_tap: 8-bit with footer, 64-bit with
// footer, and 8-bit without footer using an 8-bit length field.
module tb_axis_frame_length_tap;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expired(input string name);
    checks++;
    failures++;
    $display("FAIL %s wait bound expired", name);
  endtask

  // Instance A: 8-bit data, footer enabled, 16-bit length
  logic [7:0]  a_sd, a_md;
  logic        a_sk, a_mk, a_sv, a_sr, a_sl, a_mv, a_mr, a_ml, a_lv, a_lr;
  logic [15:0] a_ld;

  axis_frame_length_tap dut_a (
    .clk(clk), .rst(rst),
    .s_axis_tdata(a_sd), .s_axis_tkeep(a_sk), .s_axis_tvalid(a_sv),
    .s_axis_tready(a_sr), .s_axis_tlast(a_sl),
    .m_axis_tdata(a_md), .m_axis_tkeep(a_mk), .m_axis_tvalid(a_mv),
    .m_axis_tready(a_mr), .m_axis_tlast(a_ml),
    .m_axis_frame_length_tdata(a_ld), .m_axis_frame_length_tvalid(a_lv),
    .m_axis_frame_length_tready(a_lr)
  );

  // Instance B: 64-bit data, footer enabled
  logic [63:0] b_sd, b_md;
  logic [7:0]  b_sk, b_mk;
  logic        b_sv, b_sr, b_sl, b_mv, b_mr, b_ml, b_lv, b_lr;
  logic [15:0] b_ld;

  axis_frame_length_tap #(.C_AXIS_TDATA_WIDTH(64)) dut_b (
    .clk(clk), .rst(rst),
    .s_axis_tdata(b_sd), .s_axis_tkeep(b_sk), .s_axis_tvalid(b_sv),
    .s_axis_tready(b_sr), .s_axis_tlast(b_sl),
    .m_axis_tdata(b_md), .m_axis_tkeep(b_mk), .m_axis_tvalid(b_mv),
    .m_axis_tready(b_mr), .m_axis_tlast(b_ml),
    .m_axis_frame_length_tdata(b_ld), .m_axis_frame_length_tvalid(b_lv),
    .m_axis_frame_length_tready(b_lr)
  );

  // Instance C: 8-bit data, no footer, 8-bit length (saturates at 255)
  logic [7:0] c_sd, c_md, c_ld;
  logic       c_sk, c_mk, c_sv, c_sr, c_sl, c_mv, c_mr, c_ml, c_lv, c_lr;

  axis_frame_length_tap #(.FRAME_LENGTH_WIDTH(8), .ENABLE_TIMESTAMP_FOOTER(0)) dut_c (
    .clk(clk), .rst(rst),
    .s_axis_tdata(c_sd), .s_axis_tkeep(c_sk), .s_axis_tvalid(c_sv),
    .s_axis_tready(c_sr), .s_axis_tlast(c_sl),
    .m_axis_tdata(c_md), .m_axis_tkeep(c_mk), .m_axis_tvalid(c_mv),
    .m_axis_tready(c_mr), .m_axis_tlast(c_ml),
    .m_axis_frame_length_tdata(c_ld), .m_axis_frame_length_tvalid(c_lv),
    .m_axis_frame_length_tready(c_lr)
  );

  logic [9:0]  dq[$];
  logic [15:0] lqa[$], lqb[$];
  logic [7:0]  lqc[$];
  logic        held_v = 1'b0;
  logic [15:0] held;

  // Monitors: sample between active edges, pop on every output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_mv && a_mr) begin
        if (dq.size() == 0) expired("a_data_unexpected");
        else chk("a_data", {a_md, a_mk, a_ml}, dq.pop_front());
      end
      if (a_lv && a_lr) begin
        if (lqa.size() == 0) expired("a_len_unexpected");
        else chk("a_len", a_ld, lqa.pop_front());
      end
      if (a_lv && !a_lr) begin
        if (held_v) chk("a_len_stable", a_ld, held);
        held_v = 1'b1;
        held   = a_ld;
      end else held_v = 1'b0;
      if (a_lv && !a_lr && a_sv && a_sl) chk("a_tlast_stall", a_sr, 1'b0);
      if (b_lv && b_lr) begin
        if (lqb.size() == 0) expired("b_len_unexpected");
        else chk("b_len", b_ld, lqb.pop_front());
      end
      if (c_lv && c_lr) begin
        if (lqc.size() == 0) expired("c_len_unexpected");
        else chk("c_len", c_ld, lqc.pop_front());
      end
    end
  end

  task automatic a_beat(input logic [7:0] d, input logic k, input logic l);
    int n = 0;
    dq.push_back({d, k, l});
    a_sd = d; a_sk = k; a_sl = l; a_sv = 1'b1;
    @(negedge clk);
    while (!a_sr && n < 400) begin n++; @(negedge clk); end
    if (!a_sr) expired("a_accept");
    @(posedge clk); #1;
    a_sv = 1'b0;
  endtask

  // n beats total; the last 9 carry the footer when the frame is long enough.
  task automatic send_a(input int n, input logic [15:0] exp, input int null_at);
    logic [71:0] ft = 72'hABFEDCBA9876543210;
    logic [7:0]  b;
    lqa.push_back(exp);
    for (int i = 0; i < n; i++) begin
      if (i == null_at) a_beat(8'h5A, 1'b0, 1'b0);
      if (n >= 9 && i >= n - 9) b = ft[71 - 8 * (i - (n - 9)) -: 8];
      else b = 8'(i * 3 + n);
      a_beat(b, 1'b1, i == n - 1);
    end
  endtask

  task automatic b_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int n = 0;
    b_sd = d; b_sk = k; b_sl = l; b_sv = 1'b1;
    @(negedge clk);
    while (!b_sr && n < 400) begin n++; @(negedge clk); end
    if (!b_sr) expired("b_accept");
    @(posedge clk); #1;
    b_sv = 1'b0;
  endtask

  task automatic c_beat(input logic [7:0] d, input logic l);
    int n = 0;
    c_sd = d; c_sk = 1'b1; c_sl = l; c_sv = 1'b1;
    @(negedge clk);
    while (!c_sr && n < 400) begin n++; @(negedge clk); end
    if (!c_sr) expired("c_accept");
    @(posedge clk); #1;
    c_sv = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    a_sd = '0; a_sk = 1'b0; a_sv = 1'b0; a_sl = 1'b0; a_mr = 1'b1; a_lr = 1'b1;
    b_sd = '0; b_sk = '0;   b_sv = 1'b0; b_sl = 1'b0; b_mr = 1'b1; b_lr = 1'b1;
    c_sd = '0; c_sk = 1'b0; c_sv = 1'b0; c_sl = 1'b0; c_mr = 1'b1; c_lr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", a_mv, 1'b0);
    chk("rst_len_tvalid", a_lv, 1'b0);
    chk("rst_s_tready", a_sr, 1'b0);
    chk("rst_m_tdata", a_md, 8'h00);
    chk("rst_len_tdata", a_ld, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;

    // 64 payload + 9 footer, everything ready
    send_a(73, 16'd64, -1);
    chk("a_len_latency", a_lv, 1'b1);
    chk("a_len_t1", a_ld, 16'd64);
    // 11 payload + footer with a null beat inside; then a 5-byte runt clamps to 0
    send_a(20, 16'd11, 5);
    send_a(5, 16'd0, -1);

    // both readies low until cycle 50
    a_mr = 1'b0; a_lr = 1'b0;
    fork
      send_a(73, 16'd64, -1);
      begin repeat (50) @(posedge clk); #1; a_mr = 1'b1; a_lr = 1'b1; end
    join
    repeat (3) @(posedge clk); #1;

    // back-to-back frames with late length pulses
    a_lr = 1'b0;
    fork
      begin
        send_a(69, 16'd60, -1);
        send_a(1523, 16'd1514, -1);
        send_a(73, 16'd64, -1);
      end
      begin
        for (int p = 0; p < 3; p++) begin
          n = 0;
          @(negedge clk);
          while (!a_lv && n < 3000) begin n++; @(negedge clk); end
          if (!a_lv) expired("a_len_wait");
          repeat (100) @(posedge clk); #1;
          a_lr = 1'b1;
          @(posedge clk); #1;
          a_lr = 1'b0;
        end
      end
    join
    a_lr = 1'b1;
    repeat (3) @(posedge clk); #1;

    // reset in the middle of a frame
    for (int i = 0; i < 20; i++) a_beat(8'(i), 1'b1, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_m_tvalid", a_mv, 1'b0);
    chk("midrst_len_tvalid", a_lv, 1'b0);
    chk("midrst_s_tready", a_sr, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    dq.delete();
    send_a(73, 16'd64, -1);

    // 64-bit: 61 payload + 9 footer = 70 bytes, last keep 3F
    lqb.push_back(16'd61);
    for (int i = 0; i < 8; i++) b_beat({8{8'(i)}}, 8'hFF, 1'b0);
    b_beat(64'h0000_ABFE_DCBA_9876, 8'h3F, 1'b1);

    // no footer: 64 bytes, then 300 bytes saturating the 8-bit length
    lqc.push_back(8'd64);
    for (int i = 0; i < 64; i++) c_beat(8'(i), i == 63);
    lqc.push_back(8'd255);
    for (int i = 0; i < 300; i++) c_beat(8'(i), i == 299);

    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("a_data_drained", 64'(dq.size()), 64'd0);
    chk("a_len_drained", 64'(lqa.size()), 64'd0);
    chk("b_len_drained", 64'(lqb.size()), 64'd0);
    chk("c_len_drained", 64'(lqc.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
